// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: controller state encoding, default
//                payload width and the cycles-per-bit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_BREAK = 2'd2,
        S_DRAIN = 2'd3
    } uart_state_e;

    localparam int DEFAULT_PAYLOAD_WIDTH = 8;

    // Rounded to the nearest integer so the bit-centre error stays below half a cycle.
    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
// ============================================================================
//  Module      : uart_rx_ctrl_if
//  Description : Valid/ready stream carrying buffered bytes and their
//                start-of-message tag to the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_ctrl_if #(
    parameter int PAYLOAD_WIDTH = 8
);
    logic                     m_valid;
    logic                     m_ready;
    logic [PAYLOAD_WIDTH-1:0] m_data;
    logic                     m_first;

    modport master (output m_valid, output m_data, output m_first, input m_ready);
    modport slave  (input m_valid, input m_data, input m_first, output m_ready);
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous show-ahead FIFO; a push while full is accepted
//                only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    input  wire logic [WIDTH-1:0]           wdata_i,
    output logic      [WIDTH-1:0]           rdata_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic      [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_wr;
    logic             w_rd;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_wr    = push_i && (!full_o || pop_i);
    assign w_rd    = pop_i && !empty_o;
    assign count_o = count_q;
    // Head is forced to zero while empty so the outputs are clean after reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : Sequences uart_rx: enable gating, break filtering, message
//                tagging by idle timeout, byte buffering and sticky status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int PAYLOAD_WIDTH  = DEFAULT_PAYLOAD_WIDTH,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 52080
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          ctrl_enable,
    input  wire logic                          clr_status,
    input  wire logic                          rx_valid,
    input  wire logic                          rx_break,
    input  wire logic [PAYLOAD_WIDTH-1:0]      rx_data,
    output logic                               uart_rx_en,
    uart_rx_ctrl_if.master                     m_if,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               overrun,
    output logic                               break_det,
    output logic                               idle_timeout
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam int                ENTRY_W  = PAYLOAD_WIDTH + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    uart_state_e        state_q, state_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               overrun_q, overrun_d;
    logic               break_q, break_d;
    logic               timeout_q, timeout_d;

    logic               w_push;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_break_seen;
    logic [ENTRY_W-1:0] w_head;

    assign w_pop = !w_empty && m_if.m_ready;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i ({!armed_q, rx_data}),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        idle_cnt_d   = idle_cnt_q;
        timeout_d    = 1'b0;
        w_push       = 1'b0;
        w_push_ok    = 1'b0;
        w_break_seen = 1'b0;

        case (state_q)
            S_OFF: begin
                if (ctrl_enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A disable overrides break handling, so the frame is buffered like data.
                w_push       = rx_valid && (!rx_break || !ctrl_enable);
                w_break_seen = rx_valid && rx_break;
                w_push_ok    = w_push && (!w_full || w_pop);
                if (w_push_ok) begin
                    armed_d    = 1'b1;
                    idle_cnt_d = '0;
                end else if (armed_q) begin
                    if (idle_cnt_q == CNT_LAST) begin
                        timeout_d  = 1'b1;
                        armed_d    = 1'b0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
                if (!ctrl_enable) begin
                    state_d = S_DRAIN;
                end else if (w_break_seen) begin
                    state_d    = S_BREAK;
                    armed_d    = 1'b0;
                    idle_cnt_d = '0;
                end
            end
            S_BREAK: begin
                if (rx_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CNT_LAST) begin
                    state_d    = S_RUN;
                    armed_d    = 1'b0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
                if (!ctrl_enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ctrl_enable) begin
                    state_d = S_RUN;
                end else if (w_empty) begin
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase

        overrun_d = (overrun_q && !clr_status) || (w_push && w_full && !w_pop);
        break_d   = (break_q && !clr_status) || w_break_seen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            armed_q    <= 1'b0;
            idle_cnt_q <= '0;
            overrun_q  <= 1'b0;
            break_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            idle_cnt_q <= idle_cnt_d;
            overrun_q  <= overrun_d;
            break_q    <= break_d;
            timeout_q  <= timeout_d;
        end
    end

    assign uart_rx_en   = (state_q == S_RUN) || (state_q == S_BREAK);
    assign m_if.m_valid = !w_empty;
    assign m_if.m_data  = w_head[PAYLOAD_WIDTH-1:0];
    assign m_if.m_first = w_head[PAYLOAD_WIDTH];
    assign overrun      = overrun_q;
    assign break_det    = break_q;
    assign idle_timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Self-checking bench for uart_rx_ctrl with a behavioural
//                model and a byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;
    localparam int PW    = 8;
    localparam int DEPTH = 8;
    localparam int TO    = 128;

    localparam int M_OFF   = 0;
    localparam int M_RUN   = 1;
    localparam int M_BREAK = 2;
    localparam int M_DRAIN = 3;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          ctrl_enable = 1'b0;
    logic          clr_status  = 1'b0;
    logic          rx_valid    = 1'b0;
    logic          rx_break    = 1'b0;
    logic [PW-1:0] rx_data     = '0;
    logic          uart_rx_en;
    logic [$clog2(DEPTH):0] fifo_count;
    logic          overrun;
    logic          break_det;
    logic          idle_timeout;

    uart_rx_ctrl_if #(.PAYLOAD_WIDTH(PW)) m_if ();

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .PAYLOAD_WIDTH  (PW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_enable  (ctrl_enable),
        .clr_status   (clr_status),
        .rx_valid     (rx_valid),
        .rx_break     (rx_break),
        .rx_data      (rx_data),
        .uart_rx_en   (uart_rx_en),
        .m_if         (m_if),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .break_det    (break_det),
        .idle_timeout (idle_timeout)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          checking = 1'b0;
    logic [PW:0] sb_q[$];

    // Reference model: values expected after the next rising edge.
    int  md_state = M_OFF;
    bit  md_armed = 1'b0;
    int  md_quiet = 0;
    int  md_occ   = 0;
    bit  md_ovr   = 1'b0;
    bit  md_brk   = 1'b0;
    bit  md_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    logic [31:0] st_act, st_exp;
    bit          s_pop, s_full, s_want, s_acc, s_drop, s_brk_seen;
    int          s_next;

    always @(negedge clk) begin
        if (checking) begin
            st_act = 32'({uart_rx_en, m_if.m_valid, 4'(fifo_count), overrun, break_det,
                          idle_timeout, (m_if.m_valid ? 9'd0 : {m_if.m_first, m_if.m_data})});
            st_exp = 32'({(md_state == M_RUN || md_state == M_BREAK), (md_occ > 0), 4'(md_occ),
                          md_ovr, md_brk, md_to, 9'd0});
            check("status", st_act, st_exp);
        end
        if (rst) begin
            md_state = M_OFF; md_armed = 0; md_quiet = 0; md_occ = 0;
            md_ovr = 0; md_brk = 0; md_to = 0;
            sb_q.delete();
        end else begin
            s_pop      = (md_occ > 0) && m_if.m_ready;
            s_full     = (md_occ == DEPTH);
            s_want     = 0;
            s_brk_seen = 0;
            s_next     = md_state;
            md_to      = 0;
            if (md_state == M_RUN) begin
                s_want     = rx_valid && (!rx_break || !ctrl_enable);
                s_brk_seen = rx_valid && rx_break;
            end
            s_acc  = s_want && (!s_full || s_pop);
            s_drop = s_want && s_full && !s_pop;
            if (s_acc) sb_q.push_back({!md_armed, rx_data});
            case (md_state)
                M_OFF: if (ctrl_enable) s_next = M_RUN;
                M_RUN: begin
                    if (s_acc) begin
                        md_armed = 1; md_quiet = 0;
                    end else if (md_armed) begin
                        if (md_quiet == TO - 1) begin
                            md_to = 1; md_armed = 0; md_quiet = 0;
                        end else md_quiet++;
                    end
                    if (!ctrl_enable) s_next = M_DRAIN;
                    else if (s_brk_seen) begin
                        s_next = M_BREAK; md_armed = 0; md_quiet = 0;
                    end
                end
                M_BREAK: begin
                    if (rx_valid) md_quiet = 0;
                    else if (md_quiet == TO - 1) begin
                        s_next = M_RUN; md_armed = 0; md_quiet = 0;
                    end else md_quiet++;
                    if (!ctrl_enable) s_next = M_DRAIN;
                end
                default: begin
                    if (ctrl_enable) s_next = M_RUN;
                    else if (md_occ == 0) s_next = M_OFF;
                end
            endcase
            md_state = s_next;
            md_occ   = md_occ + int'(s_acc) - int'(s_pop);
            md_ovr   = (md_ovr && !clr_status) || s_drop;
            md_brk   = (md_brk && !clr_status) || s_brk_seen;
        end
    end

    logic [PW:0] mon_exp;
    always @(negedge clk) begin
        if (checking && !rst && m_if.m_valid && m_if.m_ready) begin
            if (sb_q.size() == 0) begin
                check("pop_unexpected", 32'({m_if.m_first, m_if.m_data}), 32'h1000);
            end else begin
                mon_exp = sb_q.pop_front();
                check("pop_data", 32'({m_if.m_first, m_if.m_data}), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [PW-1:0] d, input bit brk);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_break = brk;
        tick();
        rx_valid = 1'b0;
        rx_break = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        m_if.m_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (!m_if.m_valid) break;
            tick();
        end
        check("drain_empty", 32'(m_if.m_valid), 32'd0);
    endtask

    initial begin
        m_if.m_ready = 1'b0;
        idle(3);
        rst      = 1'b0;
        checking = 1'b1;

        // Basic reception with one message ending on idle timeout
        m_if.m_ready = 1'b1;
        ctrl_enable  = 1'b1;
        tick();
        send(8'h41, 0); idle(100);
        send(8'h42, 0); idle(100);
        send(8'h43, 0); idle(TO + 10);

        // Overrun
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'(i), 0);
        idle(3);
        pulse_clr();
        drain(20);
        m_if.m_ready = 1'b0;

        // Push while full with a same-cycle pop
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 0);
        rx_valid = 1'b1; rx_data = 8'hAA; m_if.m_ready = 1'b1;
        tick();
        rx_valid = 1'b0; m_if.m_ready = 1'b0;
        idle(2);
        drain(20);

        // Break frame then silence
        send(8'h00, 1); idle(50);
        send(8'h55, 0); idle(TO + 5);
        send(8'h66, 0); idle(5);
        pulse_clr();

        // Randomised bursts and idle gaps
        for (int seg = 0; seg < 14; seg++) begin
            int busy;
            busy = $urandom_range(20, 80);
            for (int c = 0; c < busy; c++) begin
                rx_valid     = ($urandom_range(0, 2) == 0);
                rx_data      = 8'($urandom);
                rx_break     = ($urandom_range(0, 40) == 0);
                m_if.m_ready = $urandom_range(0, 1) == 1;
                clr_status   = ($urandom_range(0, 30) == 0);
                if ($urandom_range(0, 99) == 0) ctrl_enable = !ctrl_enable;
                tick();
            end
            rx_valid = 0; rx_break = 0; clr_status = 0;
            ctrl_enable  = 1'b1;
            m_if.m_ready = 1'b1;
            idle($urandom_range(10, TO + 40));
        end

        // Disable and drain
        drain(50);
        idle(TO + 5);
        m_if.m_ready = 1'b0;
        send(8'h31, 0); send(8'h32, 0); send(8'h33, 0);
        ctrl_enable = 1'b0;
        tick();
        idle(3);
        drain(20);
        idle(3);
        ctrl_enable = 1'b1;
        tick();

        // Reset with five bytes buffered and overrun set
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'(8'h80 + i), 0);
        m_if.m_ready = 1'b1;
        idle(3);
        m_if.m_ready = 1'b0;
        idle(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(5);

        drain(20);
        idle(3);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller sequencing the UART receive datapath (uart_rx). It gates the receiver enable, filters break frames, and buffers received bytes in a small synchronous FIFO. Each byte is tagged with start-of-message, where a message is delimited by line-idle timeout. Buffered bytes go to a valid/ready consumer, and sticky overrun/break status goes to a register block.

Parameters:
PAYLOAD_WIDTH, 8, data bits per frame; must match uart_rx
FIFO_DEPTH, 8, entries; power of 2, minimum 2
TIMEOUT_CYCLES, 52080, idle clk cycles after the last accepted byte that end a message (10 bit times at 50 MHz / 9600 baud)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
ctrl_enable  in  1  software enable for reception
clr_status  in  1  one-cycle pulse; clears the sticky flags
rx_valid  in  1  one-cycle pulse from uart_rx: frame complete
rx_break  in  1  from uart_rx; qualifies rx_valid as a break frame
rx_data  in  PAYLOAD_WIDTH  received byte from uart_rx
uart_rx_en  out  1  enable to uart_rx
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts the head entry
m_data  out  PAYLOAD_WIDTH  head byte
m_first  out  1  head byte is the first of a message
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overrun  out  1  sticky: a byte was dropped because the FIFO was full
break_det  out  1  sticky: a break frame was seen
idle_timeout  out  1  one-cycle pulse when a message ends

Behaviour:
- Reset (rst=1 at a clk edge): state S_OFF, FIFO emptied, pointers 0. Outputs: uart_rx_en=0, m_valid=0, m_data=0, m_first=0, fifo_count=0, overrun=0, break_det=0, idle_timeout=0. Idle counter=0, armed=0. Reset mid-message discards all buffered data.
- Registered FSM, states:
  - S_OFF: uart_rx_en=0. Goes to S_RUN when ctrl_enable=1.
  - S_RUN: uart_rx_en=1.
    - rx_valid & !rx_break: push {armed==0, rx_data}, then set armed=1 and clear the idle counter.
    - rx_valid & rx_break: no push; set break_det; go to S_BREAK.
    - ctrl_enable=0: go to S_DRAIN. ctrl_enable takes priority over a same-cycle break; that same-cycle byte is still pushed.
  - S_BREAK: uart_rx_en=1.
    - All rx_valid frames are discarded, including non-break frames.
    - The idle counter restarts on every rx_valid.
    - Goes to S_RUN after TIMEOUT_CYCLES consecutive cycles with no rx_valid, with armed=0.
    - ctrl_enable=0 goes to S_DRAIN.
  - S_DRAIN: uart_rx_en=0. The consumer keeps popping.
    - Goes to S_OFF when the FIFO is empty.
    - ctrl_enable=1 goes to S_RUN; the buffered bytes are kept.
- Idle timeout, S_RUN only:
  - While armed=1, the counter increments each cycle with no accepted push.
  - When the counter reaches TIMEOUT_CYCLES-1: idle_timeout=1 for one cycle, armed=0, counter=0.
  - The next pushed byte carries m_first=1.
  - The counter is $clog2(TIMEOUT_CYCLES) bits wide and never wraps.
- FIFO:
  - Show-ahead. m_data and m_first reflect the head entry whenever m_valid=1.
  - Pop occurs on m_valid & m_ready.
  - Latency: rx_valid at edge N gives m_valid=1 after edge N, if the FIFO was previously empty.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Full/overrun:
  - A push while full with no same-cycle pop drops the byte, sets overrun, and leaves FIFO contents and count unchanged.
  - A push while full with a same-cycle pop is accepted; count stays FIFO_DEPTH.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged.
  - A pop while empty is impossible (m_valid=0).
  - A dropped byte does not clear armed and does not restart the idle counter.
- Sticky flags: clr_status clears overrun and break_det. A same-cycle set event wins, so the flag stays 1.
- rx_valid arriving in S_OFF is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (S_OFF=0, S_RUN=1, S_BREAK=2, S_DRAIN=3, 2 bits);
  - the default PAYLOAD_WIDTH;
  - the cycles-per-bit computation shared with uart_rx/uart_tx.
- Sub-module uart_rx_fifo: a parameterised synchronous show-ahead FIFO, width PAYLOAD_WIDTH+1, depth FIFO_DEPTH, with push/pop/full/empty/count. Its push-while-full-with-pop rule is exactly as stated above.

Test Plan:
- Basic reception: rst, ctrl_enable=1, then rx_valid with 0x41, 0x42, 0x43 spaced 100 cycles, m_ready=1 → uart_rx_en=1 one cycle after enable. m_data=0x41/0x42/0x43 with m_first=1/0/0. One idle_timeout pulse fires exactly TIMEOUT_CYCLES cycles after 0x43.
- Overrun: m_ready=0, push 9 bytes 0x00..0x08 with FIFO_DEPTH=8 → fifo_count=8 and overrun=1. Draining yields 0x00..0x07, and 0x08 is absent. clr_status gives overrun=0.
- Full push with simultaneous pop: FIFO full, rx_valid (0xAA) and m_ready=1 in the same cycle → count stays 8, overrun=0, and 0xAA is the last entry drained.
- Break: rx_valid with rx_break=1 and rx_data=0x00, then rx_valid with 0x55 after 1000 cycles → break_det=1, nothing pushed. After TIMEOUT_CYCLES of silence, 0x66 is pushed with m_first=1.
- Disable/drain: 3 bytes buffered, m_ready=0, ctrl_enable=0 → uart_rx_en=0 next cycle, state S_DRAIN. After 3 pops, state S_OFF with m_valid=0.
- Reset mid-operation: 5 bytes buffered with overrun=1, assert rst for one cycle → every output returns to its reset value, state S_OFF.
